// File: rtl/spike_event_fifo.sv
// spike_event_fifo
// Turns rising edges on a layer's spike outputs into {index, timestamp}
// events and queues them in a synchronous FIFO with a valid/ready drain.
// Spikes that arrive while the FIFO is full wait in a per-neuron pending
// mask. A second edge on an already-pending neuron is a lost spike and
// sets the sticky overflow flag.
// Optional feature macro: SPIKE_FIFO_DROP_COUNT_EN adds an 8-bit
// saturating drop_count output.
module spike_event_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter int TS_W  = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int EW    = IDX_W + TS_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          delay_clk,
  input  logic [N-1:0]  spike_in,
  output logic [EW-1:0] event_data,
  output logic          event_valid,
  input  logic          event_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          clear_overflow
`ifdef SPIKE_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]    drop_count
`endif
);

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     r_spike_prev;
  logic             r_dclk_prev;
  logic [TS_W-1:0]  r_ts;
  logic             r_overflow;

  logic [N-1:0]     w_edge;
  logic [N-1:0]     w_cand;
  logic [N-1:0]     w_onehot;
  logic [N-1:0]     w_lost;
  logic [IDX_W-1:0] w_sel;
  logic             w_found;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ts_inc;

  assign w_edge   = spike_in & ~r_spike_prev & {N{enable}};
  assign w_cand   = r_pending | w_edge;
  assign w_valid  = (r_count != '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = w_valid & event_ready;
  assign w_push   = w_found & (~w_full | w_pop);
  assign w_onehot = w_push ? (N'(1) << w_sel) : '0;
  assign w_lost   = w_edge & r_pending & ~w_onehot;
  assign w_ts_inc = enable & delay_clk & ~r_dclk_prev;

  assign event_data  = r_mem[r_rp];
  assign event_valid = w_valid;
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;

  // Fixed-priority arbiter: lowest set candidate index wins.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_cand[i] && !w_found) begin
        w_sel   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  // Edge history and time-step counter; history tracks even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_prev <= '0;
      r_dclk_prev  <= 1'b0;
      r_ts         <= '0;
    end else begin
      r_spike_prev <= spike_in;
      r_dclk_prev  <= delay_clk;
      if (w_ts_inc) r_ts <= r_ts + 1'b1;
    end
  end

  // Pending mask: candidates not pushed this cycle stay held (merged).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_cand & ~w_onehot;
  end

  // FIFO storage, pointers and occupancy; push uses pre-increment timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {w_sel, r_ts};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky loss flag; a loss in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_overflow <= 1'b0;
    else if (|w_lost)          r_overflow <= 1'b1;
    else if (clear_overflow)   r_overflow <= 1'b0;
  end

`ifdef SPIKE_FIFO_DROP_COUNT_EN
  logic [7:0]  r_drop;
  logic [31:0] w_drop_sum;

  // Clear first, then add this cycle's losses, saturating at 255.
  always_comb begin
    w_drop_sum = (clear_overflow ? 32'd0 : {24'd0, r_drop})
               + 32'($countones(w_lost));
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_drop <= '0;
    else if (w_drop_sum > 32'd255) r_drop <= 8'd255;
    else                        r_drop <= w_drop_sum[7:0];
  end

  assign drop_count = r_drop;
`endif

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed testbench for spike_event_fifo (N=8, DEPTH=8, TS_W=8).
module tb_spike_event_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        delay_clk;
  logic [7:0]  spike_in;
  logic [10:0] event_data;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        clear_overflow;
`ifdef SPIKE_FIFO_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int total = 0;
  int bad   = 0;

  spike_event_fifo #(.N(8), .DEPTH(8), .TS_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .delay_clk      (delay_clk),
    .spike_in       (spike_in),
    .event_data     (event_data),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef SPIKE_FIFO_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      delay_clk = 1'b1; tick();
      delay_clk = 1'b0; tick();
    end
  endtask

  initial begin
    logic [10:0] exp_head [8];
    logic [7:0]  s;

    rst_n = 1'b0; enable = 1'b0; delay_clk = 1'b0; spike_in = '0;
    event_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(event_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_data",  32'(event_data), 32'h000);
    rst_n = 1'b1; enable = 1'b1;
    tick();

    // single spike on bit 3, one-cycle latency, then popped
    event_ready = 1'b1; spike_in = 8'h08;
    tick();
    chk("t1_valid", 32'(event_valid), 32'd1);
    chk("t1_data",  32'(event_data), 32'h300);
    chk("t1_count", 32'(fifo_count), 32'd1);
    tick();
    chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
    chk("t1_valid_after_pop", 32'(event_valid), 32'd0);
    spike_in = '0; tick();

    // three simultaneous edges enter lowest index first
    event_ready = 1'b0; spike_in = 8'h85;
    tick(); chk("t2_count1", 32'(fifo_count), 32'd1);
    tick(); chk("t2_count2", 32'(fifo_count), 32'd2);
    tick(); chk("t2_count3", 32'(fifo_count), 32'd3);
    spike_in = '0; tick();
    chk("t2_count_hold", 32'(fifo_count), 32'd3);
    chk("t2_head0", 32'(event_data), 32'h000);
    event_ready = 1'b1;
    tick(); chk("t2_head2", 32'(event_data), 32'h200);
    tick(); chk("t2_head7", 32'(event_data), 32'h700);
    tick(); chk("t2_empty", 32'(fifo_count), 32'd0);
    event_ready = 1'b0;

    // timestamps: 5 pulses, wrap at 256, increment coincident with push
    pulse(5);
    spike_in = 8'h02; tick();
    chk("t3_ts5", 32'(event_data), 32'h105);
    spike_in = '0; event_ready = 1'b1; tick(); event_ready = 1'b0;
    pulse(250);
    spike_in = 8'h04; tick();
    chk("t3_ts255", 32'(event_data), 32'h2FF);
    spike_in = '0; event_ready = 1'b1; tick(); event_ready = 1'b0;
    pulse(1);
    spike_in = 8'h02; tick();
    chk("t3_wrap0", 32'(event_data), 32'h100);
    spike_in = '0; event_ready = 1'b1; tick(); event_ready = 1'b0;
    spike_in = 8'h20; delay_clk = 1'b1; tick();
    chk("t3_old_ts", 32'(event_data), 32'h500);
    spike_in = '0; delay_clk = 1'b0; event_ready = 1'b1; tick(); event_ready = 1'b0;
    spike_in = 8'h40; tick();
    chk("t3_new_ts", 32'(event_data), 32'h601);
    spike_in = '0; event_ready = 1'b1; tick(); event_ready = 1'b0;
    chk("t3_empty", 32'(fifo_count), 32'd0);

    // disabled: no edges, no timestamp advance
    enable = 1'b0; spike_in = 8'h01; delay_clk = 1'b1; tick();
    chk("t3_dis_valid", 32'(event_valid), 32'd0);
    delay_clk = 1'b0; enable = 1'b1; tick();
    chk("t3_dis_noedge", 32'(fifo_count), 32'd0);
    spike_in = '0; tick();

    // fill to 8, pending hold, loss, clear/loss race, push+pop while full
    spike_in = 8'hFF;
    repeat (8) tick();
    chk("t4_full", 32'(fifo_count), 32'd8);
    chk("t4_head", 32'(event_data), 32'h001);
    spike_in = '0; tick();
    spike_in = 8'h10; tick();
    chk("t4_pend_noovf", 32'(overflow), 32'd0);
    chk("t4_pend_count", 32'(fifo_count), 32'd8);
    spike_in = '0; tick();
    spike_in = 8'h10; tick();
    chk("t4_loss_ovf", 32'(overflow), 32'd1);
`ifdef SPIKE_FIFO_DROP_COUNT_EN
    chk("t4_drop1", 32'(drop_count), 32'd1);
`endif
    spike_in = '0; tick();
    spike_in = 8'h10; clear_overflow = 1'b1; tick();
    chk("t4_loss_wins", 32'(overflow), 32'd1);
`ifdef SPIKE_FIFO_DROP_COUNT_EN
    chk("t4_drop_clr_loss", 32'(drop_count), 32'd1);
`endif
    spike_in = '0; tick();
    chk("t4_cleared", 32'(overflow), 32'd0);
`ifdef SPIKE_FIFO_DROP_COUNT_EN
    chk("t4_drop0", 32'(drop_count), 32'd0);
`endif
    clear_overflow = 1'b0;
    event_ready = 1'b1; tick();
    chk("t4_pushpop_count", 32'(fifo_count), 32'd8);
    chk("t4_pushpop_head", 32'(event_data), 32'h101);

    // full with continuous pops and rotating edges: stays full, FIFO order
    exp_head[0] = 11'h101; exp_head[1] = 11'h201; exp_head[2] = 11'h301;
    exp_head[3] = 11'h401; exp_head[4] = 11'h501; exp_head[5] = 11'h601;
    exp_head[6] = 11'h701; exp_head[7] = 11'h401;
    for (int i = 0; i < 8; i++) begin
      s = 8'd1 << i;
      spike_in = s;
      chk($sformatf("t5_head%0d", i), 32'(event_data), 32'(exp_head[i]));
      tick();
      chk($sformatf("t5_count%0d", i), 32'(fifo_count), 32'd8);
    end
    chk("t5_no_loss", 32'(overflow), 32'd0);
    spike_in = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_drain%0d", i), 32'(event_data), 32'((i << 8) | 1));
      tick();
    end
    chk("t5_empty", 32'(fifo_count), 32'd0);
    event_ready = 1'b0;

    // reset mid-burst: 5 queued, 2 pending
    spike_in = 8'h7F;
    repeat (5) tick();
    chk("t6_count5", 32'(fifo_count), 32'd5);
    rst_n = 1'b0; spike_in = '0;
    #1;
    chk("t6_rst_valid", 32'(event_valid), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_post_valid", 32'(event_valid), 32'd0);
    chk("t6_post_count", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_event_fifo.md
# spike_event_fifo

Downstream collector for the output spikes of a layer of `NeuronWithDelays` neurons. Converts each rising edge on a neuron's `spike_out` into a timestamped event word `{neuron index, time step}`. Buffers events in a synchronous FIFO and drains them over a valid/ready handshake toward the chip output or readout logic. Holds spikes that arrive while the FIFO is full in a per-neuron pending mask and flags any that are lost.

## Interface
Parameters:
- `N`, 8: number of neuron spike inputs; `IDX_W = $clog2(N)` (min 1).
- `DEPTH`, 8: FIFO entries, power of two, ≥2.
- `TS_W`, 8: timestamp width.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: capture and timestamp enable.
- `delay_clk` input 1: time-step strobe in the `clk` domain, the same signal that drives the neurons' delay lines.
- `spike_in` input N: neuron `spike_out` bits.
- `event_data` output IDX_W+TS_W: `{index, timestamp}`, index in the MSBs; the FIFO head.
- `event_valid` output 1: FIFO not empty.
- `event_ready` input 1: consumer accepts the head this cycle.
- `fifo_count` output $clog2(DEPTH)+1: occupied entries.
- `overflow` output 1: sticky; at least one spike lost.
- `clear_overflow` input 1: synchronous clear of `overflow` (and the drop counter).

## Operation
- Edge detect: register `spike_prev` each cycle, also while `enable`=0. `edge = spike_in & ~spike_prev & {N{enable}}`.
- Timestamp: counter `ts` increments on each rising edge of `delay_clk` (`delay_clk & ~delay_clk_prev`) while `enable`=1. Wraps 2^TS_W−1 → 0. Frozen while `enable`=0.
- Candidates: `cand = pending | edge`. The arbiter selects the lowest set index of `cand`.
- Push is allowed when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle. On push:
  - Write `{sel_idx, ts}` to the FIFO, using the `ts` value before any increment in that cycle.
  - The selected bit is not retained in `pending`.
- Pending update: `pending_next = cand & ~push_onehot`.
- Loss: a bit whose `edge` is 1 while its `pending` bit is already 1 (and it is not pushed this cycle) is lost. `overflow` goes to 1 on the next edge. Pending bits merge; no duplicate is stored.
- Pop happens when `event_valid & event_ready`; the read pointer advances.
- With simultaneous push and pop, `count` is unchanged.
- `clear_overflow` in the same cycle as a new loss: the loss wins and `overflow` stays 1.
- `enable`=0:
  - No new edges and no `ts` advance.
  - `pending` continues to drain into the FIFO.
  - The output handshake keeps working.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- Reset values: `event_valid`=0, `fifo_count`=0, `overflow`=0. `event_data` = contents of entry 0 after reset = 0 (storage reset to 0).
- Reset also clears `pending`, `spike_prev`, `delay_clk_prev`, `ts`, and both pointers.
- Reset asserted mid-operation discards all queued and pending events immediately (asynchronous).
- Latency: a spike first high at posedge k, with the FIFO not full and no lower-index candidate, gives `event_valid`=1 and that entry at the head after posedge k, i.e. 1 cycle.
- Throughput: at most 1 push and 1 pop per cycle. N simultaneous edges take N cycles to enter the FIFO, lowest index first.
- `event_data` and `event_valid` are stable while `event_valid & ~event_ready`.
- A `ts` increment and a push in the same cycle: the push carries the old `ts`.

## Configuration
- `SPIKE_FIFO_DROP_COUNT_EN` defined:
  - Adds output `drop_count` (8 bits), which increments once per lost spike and saturates at 255.
  - Multiple simultaneous losses in one cycle add their popcount, saturating.
  - Cleared by `clear_overflow` and by reset.
- Undefined: the port and counter do not exist; only the sticky `overflow` is reported.

## Test plan
- Reset, then a single spike on `spike_in[3]` at ts=0 with `event_ready`=1 → one cycle later `event_valid`=1, `event_data`={3, 0}. Popped next cycle; `fifo_count` returns to 0.
- `spike_in` 8'b1000_0101 rises in one cycle, `event_ready`=0 → three pushes on consecutive cycles in order {0,ts}, {2,ts}, {7,ts}; `fifo_count`=3.
- Five `delay_clk` pulses, then a spike on bit 1 → `event_data`={1, 5}. With TS_W=8, 256 pulses then a spike → ts field 0 (wrap).
- `event_ready`=0, fill 8 entries, then edge on bit 4 → bit 4 held pending, `overflow`=0. A second edge on bit 4 → `overflow`=1 (`drop_count`=1 with macro). Raise `event_ready` → the bit 4 event enters while the FIFO stays full (push+pop the same cycle).
- FIFO full and `event_ready`=1 continuously with edges each cycle on rotating bits → `fifo_count` stays 8, no loss, FIFO output is in FIFO order.
- Assert `rst_n`=0 mid-burst with 5 queued and 2 pending → `event_valid`=0 and `fifo_count`=0 immediately. No stale event appears after release.
